calc1_port_scheduler: RTL and testbench
=======================================

Name: calc1_port_scheduler

Overview:
Front-end scheduler that shares one calc1 arithmetic/shift engine among four requester ports.
- Captures each port's two-cycle request (command with operand 1, then operand 2).
- Rejects invalid commands locally.
- Grants the engine round-robin and tracks in-flight operations by tag.
- Returns each result as a single-cycle response on the originating port.
- Sits between the calc1 port pins and the shared engine.

Parameters:
TIMEOUT, 64, engine cycles allowed per dispatched op before the port is failed (min 4)
TAG_W, 3, tag width: bits [0:1] port index, bit [2] per-port sequence bit

Ports:
c_clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
reqN_cmd_in  in  [0:3]  port N command, N=1..4 (0 none, 1 add, 2 sub, 5 shl, 6 shr)
reqN_data_in  in  [0:31]  port N operand (op1 with command, op2 on following cycle)
outN_resp  out  [0:1]  port N response (0 none, 1 ok, 2 error, 3 reserved/never driven)
outN_data  out  [0:31]  port N result, valid only when outN_resp!=0
alu_valid  out  1  dispatch request to engine
alu_ready  in  1  engine accepts when alu_valid&&alu_ready
alu_cmd  out  [0:3]  dispatched command
alu_op1, alu_op2  out  [0:31]  dispatched operands
alu_tag  out  [0:TAG_W-1]  dispatched tag
alu_done  in  1  engine result valid (one cycle per op)
alu_tag_in  in  [0:TAG_W-1]  tag of returned result
alu_resp  in  [0:1]  engine status (1 ok, 2 overflow/underflow)
alu_result  in  [0:31]  engine result
sched_err  out  1  sticky: spurious/late result dropped; cleared only by reset

Behaviour:
Reset:
- All outputs 0; all ports IDLE; RR pointer = port1; seq bits 0; timeout counters 0.
- Reset is asynchronous, so outputs clear without waiting for a clock.

Per-port FSM (IDLE, OP2, PEND, WAIT, RESP):
- IDLE: cmd!=0 -> latch cmd and data as op1, go to OP2.
- OP2: latch data as op2 unconditionally; cmd ignored.
  - If cmd in {1,2,5,6} -> PEND.
  - Otherwise -> RESP with resp=2, data=0; never dispatched.
- PEND: eligible for arbitration. On grant (alu_valid&&alu_ready) -> WAIT; toggle seq bit; clear timeout counter.
- WAIT: counter increments each cycle.
  - alu_done with tag matching port and current seq -> RESP with resp=alu_resp, data=alu_result.
  - Counter reaching TIMEOUT -> RESP with resp=2, data=0.
- RESP: outN_resp/outN_data driven for exactly one cycle -> IDLE.
- Commands arriving in OP2/PEND/WAIT/RESP are ignored and never queued.

Arbitration:
- Combinational from registered state; one dispatch per cycle.
- Round-robin starting at the pointer; after a grant to port k the pointer moves to k+1 (4 wraps to 1).
- Pointer is unchanged when nothing is granted.
- When alu_ready=0, alu_valid and all alu_* fields stay stable until accepted; no re-arbitration while stalled.

Latency:
- cmd in cycle 0, op2 in cycle 1, alu_valid earliest cycle 2.
- Result with alu_done in cycle n -> response visible cycle n+1.
- Invalid command -> response in cycle 3.

Result routing and boundaries:
- alu_done for a port not in WAIT, or with a seq mismatch: drop the result, set sched_err.
- A timeout and a matching alu_done in the same cycle: the result wins (resp=alu_resp).
- Responses on different ports in the same cycle are independent.
- Reset mid-operation: in-flight ops are abandoned; their later results are dropped and set sched_err.

Decomposition:
- Package calc1_sched_pkg: command codes, response codes, port state enum, TAG_W, port-index constants.
- Sub-module calc1_port_ctl: per-port FSM, operand registers, seq bit, timeout counter, response registers; instantiated 4x.
- Round-robin arbiter and result demux live in the top level.

Test Plan:
1. Port1 cmd 1 with 0x1, then 0x1FFFFFF; engine model returns 1 cycle after accept -> alu_valid cycle 2, tag 3'b000/seq, out1_resp=1, out1_data=0x2000000 in cycle 4 only.
2. All four ports issue add in the same cycle -> dispatch order 1,2,3,4 on consecutive cycles. Then ports 2 and 4 issue together -> order 2,4; responses on matching ports, no cross-talk.
3. Port3 cmd 3, then cmd 4 -> out3_resp=2, out3_data=0 in cycle 3; alu_valid never asserted for port3.
4. Port1 pending with alu_ready=0 for 10 cycles -> alu_valid high with alu_cmd/op1/op2/tag stable; a port2 request arriving meanwhile does not pre-empt. Dispatch occurs on the ready cycle.
5. TIMEOUT=16, engine never returns port2's op -> out2_resp=2, data 0 sixteen cycles after accept. Injecting the late result afterwards -> no response, sched_err=1.
6. Reset pulsed while port4 is in WAIT -> all outputs 0 immediately, sched_err=0. The old result arriving after reset is dropped and sets sched_err; a fresh port4 sub of 5-3 then returns resp 1, data 2.

Source files
------------

// File: rtl/calc1_port_scheduler_pkg.sv
// calc1 port scheduler shared definitions.
// Command/response codes, port state encoding, tag layout.
package calc1_sched_pkg;

  localparam int TAG_W = 3;
  localparam int NPORT = 4;

  localparam logic [1:0] PORT1 = 2'd0;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP2,
    ST_PEND,
    ST_WAIT,
    ST_RESP
  } port_state_e;

  function automatic logic cmd_ok(input logic [3:0] c);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (c == CMD_ADD): ok = 1'b1;
      (c == CMD_SUB): ok = 1'b1;
      (c == CMD_SHL): ok = 1'b1;
      (c == CMD_SHR): ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/calc1_port_scheduler_port_ctl.sv
// calc1 per-port request controller: capture, wait, respond.
// cmd_in/data_in pins in; eligible/cmd/op1/op2/tag_seq to arbiter;
// grant/done_* from top; resp/data one-cycle response out.
module calc1_port_ctl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cmd_in,
  input  logic [31:0] data_in,
  input  logic        grant,
  input  logic        done_hit,
  input  logic [1:0]  done_resp,
  input  logic [31:0] done_data,
  output logic        eligible,
  output logic        waiting,
  output logic        seq,
  output logic        tag_seq,
  output logic [3:0]  cmd,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [1:0]  resp,
  output logic [31:0] data
);
  import calc1_sched_pkg::*;

  localparam int CW = $clog2(TIMEOUT);
  // Last WAIT cycle: the response then lands
  // exactly TIMEOUT cycles after acceptance.
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT - 2);

  port_state_e state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [31:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic          bad_q, bad_d;
  logic          seq_q, seq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rsp_q, rsp_d;
  logic [31:0]   rdat_q, rdat_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      op1_q   <= '0;
      op2_q   <= '0;
      bad_q   <= 1'b0;
      seq_q   <= 1'b0;
      cnt_q   <= '0;
      rsp_q   <= RESP_NONE;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      bad_q   <= bad_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      rdat_q  <= rdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    bad_d   = bad_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    rdat_d  = rdat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_in != CMD_NONE) begin
          cmd_d   = cmd_in;
          op1_d   = data_in;
          state_d = ST_OP2;
        end
      end
      ST_OP2: begin
        op2_d   = data_in;
        bad_d   = !cmd_ok(cmd_q);
        state_d = ST_PEND;
      end
      ST_PEND: begin
        // A rejected command parks here one cycle,
        // never offered to the arbiter.
        if (bad_q) begin
          rsp_d   = RESP_ERR;
          rdat_d  = '0;
          state_d = ST_RESP;
        end else if (grant) begin
          seq_d   = ~seq_q;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (done_hit) begin
          rsp_d   = done_resp;
          rdat_d  = done_data;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_d   = RESP_ERR;
          rdat_d  = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign eligible = (state_q == ST_PEND) && !bad_q;
  assign waiting  = (state_q == ST_WAIT);
  assign seq      = seq_q;
  // Dispatched tag carries the post-toggle seq,
  // which is what seq_q holds while in WAIT.
  assign tag_seq  = ~seq_q;
  assign cmd      = cmd_q;
  assign op1      = op1_q;
  assign op2      = op2_q;
  assign resp = (state_q == ST_RESP) ? rsp_q
                                     : RESP_NONE;
  assign data = (state_q == ST_RESP) ? rdat_q
                                     : '0;

endmodule

// File: rtl/calc1_port_scheduler.sv
// calc1 scheduler: four request ports share one engine.
// reqN_* in, outN_* out, alu_* engine handshake, sched_err sticky.
module calc1_port_scheduler #(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 3
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic [3:0]       req1_cmd_in,
  input  logic [31:0]      req1_data_in,
  input  logic [3:0]       req2_cmd_in,
  input  logic [31:0]      req2_data_in,
  input  logic [3:0]       req3_cmd_in,
  input  logic [31:0]      req3_data_in,
  input  logic [3:0]       req4_cmd_in,
  input  logic [31:0]      req4_data_in,
  output logic [1:0]       out1_resp,
  output logic [31:0]      out1_data,
  output logic [1:0]       out2_resp,
  output logic [31:0]      out2_data,
  output logic [1:0]       out3_resp,
  output logic [31:0]      out3_data,
  output logic [1:0]       out4_resp,
  output logic [31:0]      out4_data,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic [3:0]       alu_cmd,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [TAG_W-1:0] alu_tag,
  input  logic             alu_done,
  input  logic [TAG_W-1:0] alu_tag_in,
  input  logic [1:0]       alu_resp,
  input  logic [31:0]      alu_result,
  output logic             sched_err
);
  import calc1_sched_pkg::*;

  logic [3:0]  req_cmd  [NPORT];
  logic [31:0] req_data [NPORT];
  logic [3:0]  p_cmd    [NPORT];
  logic [31:0] p_op1    [NPORT];
  logic [31:0] p_op2    [NPORT];
  logic [1:0]  p_resp   [NPORT];
  logic [31:0] p_data   [NPORT];
  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] wait_v;
  logic [NPORT-1:0] seq_v;
  logic [NPORT-1:0] tseq_v;
  logic [NPORT-1:0] grant;
  logic [NPORT-1:0] hit;

  logic [1:0] rr_q;
  logic       lock_q;
  logic [1:0] lock_idx_q;
  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic [1:0] sel;
  logic       fire;
  logic [1:0] rport;
  logic       rseq;
  logic [1:0] done_resp;
  logic       drop;

  assign req_cmd[0]  = req1_cmd_in;
  assign req_cmd[1]  = req2_cmd_in;
  assign req_cmd[2]  = req3_cmd_in;
  assign req_cmd[3]  = req4_cmd_in;
  assign req_data[0] = req1_data_in;
  assign req_data[1] = req2_data_in;
  assign req_data[2] = req3_data_in;
  assign req_data[3] = req4_data_in;

  assign out1_resp = p_resp[0];
  assign out2_resp = p_resp[1];
  assign out3_resp = p_resp[2];
  assign out4_resp = p_resp[3];
  assign out1_data = p_data[0];
  assign out2_data = p_data[1];
  assign out3_data = p_data[2];
  assign out4_data = p_data[3];

  // Engine status other than ok is reported as error,
  // so the reserved response code never escapes.
  assign done_resp = (alu_resp == RESP_OK) ? RESP_OK
                                           : RESP_ERR;

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    calc1_port_ctl #(
      .TIMEOUT(TIMEOUT)
    ) u_port (
      .clk      (c_clk),
      .rst      (reset),
      .cmd_in   (req_cmd[g]),
      .data_in  (req_data[g]),
      .grant    (grant[g]),
      .done_hit (hit[g]),
      .done_resp(done_resp),
      .done_data(alu_result),
      .eligible (elig[g]),
      .waiting  (wait_v[g]),
      .seq      (seq_v[g]),
      .tag_seq  (tseq_v[g]),
      .cmd      (p_cmd[g]),
      .op1      (p_op1[g]),
      .op2      (p_op2[g]),
      .resp     (p_resp[g]),
      .data     (p_data[g])
    );
  end

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_q;
    cand     = rr_q;
    for (int i = 0; i < NPORT; i++) begin
      cand = rr_q + 2'(i);
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // A stalled offer is pinned until the engine
  // takes it, keeping every alu_* field stable.
  assign sel       = lock_q ? lock_idx_q : pick_idx;
  assign alu_valid = lock_q | pick_vld;
  assign fire      = alu_valid && alu_ready;

  assign alu_cmd = alu_valid ? p_cmd[sel] : '0;
  assign alu_op1 = alu_valid ? p_op1[sel] : '0;
  assign alu_op2 = alu_valid ? p_op2[sel] : '0;
  assign alu_tag = alu_valid
                 ? TAG_W'({tseq_v[sel], sel})
                 : '0;

  always_comb begin
    grant = '0;
    if (fire) grant[sel] = 1'b1;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      rr_q       <= PORT1;
      lock_q     <= 1'b0;
      lock_idx_q <= PORT1;
    end else begin
      if (fire) rr_q <= sel + 2'd1;
      lock_q     <= alu_valid && !alu_ready;
      lock_idx_q <= sel;
    end
  end

  assign rport = alu_tag_in[1:0];
  assign rseq  = alu_tag_in[2];

  always_comb begin
    hit = '0;
    for (int k = 0; k < NPORT; k++) begin
      hit[k] = alu_done && (rport == 2'(k))
            && wait_v[k] && (seq_v[k] == rseq);
    end
  end

  assign drop = alu_done && (hit == '0);

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) sched_err <= 1'b0;
    else if (drop) sched_err <= 1'b1;
  end

endmodule

// File: tb/tb_calc1_port_scheduler.sv
// Bench for calc1_port_scheduler with an engine model
// and per-port response scoreboard.
module tb_calc1_port_scheduler;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_cmd  [4];
  logic [31:0] req_data [4];
  logic [1:0]  out_resp [4];
  logic [31:0] out_data [4];
  logic        alu_valid;
  logic        alu_ready = 1'b1;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_tag;
  logic        alu_done = 1'b0;
  logic [2:0]  alu_tag_in = '0;
  logic [1:0]  alu_resp = '0;
  logic [31:0] alu_result = '0;
  logic        sched_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;
  exp_t sbq [4][$];

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;
  vec_t vt [10];

  int   disp_q [$];
  int   disp_cyc [$];
  logic [3:0] hold = '0;
  logic [2:0] held_tag [4];
  logic       inj_pend = 1'b0;
  logic [2:0] inj_tag = '0;
  logic [1:0] inj_resp = '0;
  logic [31:0] inj_data = '0;

  calc1_port_scheduler #(
    .TIMEOUT(16),
    .TAG_W(3)
  ) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req1_cmd_in (req_cmd[0]),
    .req1_data_in(req_data[0]),
    .req2_cmd_in (req_cmd[1]),
    .req2_data_in(req_data[1]),
    .req3_cmd_in (req_cmd[2]),
    .req3_data_in(req_data[2]),
    .req4_cmd_in (req_cmd[3]),
    .req4_data_in(req_data[3]),
    .out1_resp   (out_resp[0]),
    .out1_data   (out_data[0]),
    .out2_resp   (out_resp[1]),
    .out2_data   (out_data[1]),
    .out3_resp   (out_resp[2]),
    .out3_data   (out_data[2]),
    .out4_resp   (out_resp[3]),
    .out4_data   (out_data[3]),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_cmd     (alu_cmd),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_tag     (alu_tag),
    .alu_done    (alu_done),
    .alu_tag_in  (alu_tag_in),
    .alu_resp    (alu_resp),
    .alu_result  (alu_result),
    .sched_err   (sched_err)
  );

  always #5 c_clk = ~c_clk;

  initial forever begin
    @(posedge c_clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic void eng_calc(
    input  logic [3:0]  c,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [1:0]  r,
    output logic [31:0] d);
    logic [32:0] s;
    r = 2'd1;
    d = '0;
    case (c)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        d = s[31:0];
        r = s[32] ? 2'd2 : 2'd1;
      end
      4'd2: begin
        d = a - b;
        r = (a < b) ? 2'd2 : 2'd1;
      end
      4'd5: d = a << b[4:0];
      4'd6: d = a >> b[4:0];
      default: r = 2'd2;
    endcase
  endfunction

  // Engine: accepts on valid&&ready, returns one
  // cycle later unless held; also injects results.
  initial begin : engine
    logic        acc;
    logic [2:0]  a_tag;
    logic [1:0]  a_resp;
    logic [31:0] a_res;
    a_tag = '0;
    a_resp = '0;
    a_res = '0;
    forever begin
      @(negedge c_clk);
      acc = alu_valid && alu_ready && !reset;
      if (acc) begin
        a_tag = alu_tag;
        eng_calc(alu_cmd, alu_op1, alu_op2,
                 a_resp, a_res);
        disp_q.push_back(int'(alu_tag[1:0]));
        disp_cyc.push_back(cyc);
      end
      @(posedge c_clk);
      #1;
      alu_done   = 1'b0;
      alu_tag_in = '0;
      alu_resp   = '0;
      alu_result = '0;
      if (inj_pend) begin
        alu_done   = 1'b1;
        alu_tag_in = inj_tag;
        alu_resp   = inj_resp;
        alu_result = inj_data;
        inj_pend   = 1'b0;
      end else if (acc) begin
        if (hold[a_tag[1:0]]) begin
          held_tag[a_tag[1:0]] = a_tag;
        end else begin
          alu_done   = 1'b1;
          alu_tag_in = a_tag;
          alu_resp   = a_resp;
          alu_result = a_res;
        end
      end
    end
  end

  initial forever begin : monitor
    exp_t e;
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      if (out_resp[p] != 2'd0) begin
        checks++;
        if (sbq[p].size() == 0) begin
          errors++;
          $display("FAIL sb_port%0d got %0d/%h want none",
                   p + 1, out_resp[p], out_data[p]);
        end else begin
          e = sbq[p].pop_front();
          if (out_resp[p] !== e.resp ||
              out_data[p] !== e.data) begin
            errors++;
            $display("FAIL sb_port%0d got %0d/%h want %0d/%h",
                     p + 1, out_resp[p], out_data[p],
                     e.resp, e.data);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge c_clk);
    #1;
  endtask

  task automatic expect_rsp(input int p,
                            input logic [1:0] r,
                            input logic [31:0] d);
    exp_t e;
    e.resp = r;
    e.data = d;
    sbq[p].push_back(e);
  endtask

  task automatic issue(input int p,
                       input logic [3:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [3:0] c2);
    tick;
    req_cmd[p]  = c;
    req_data[p] = a;
    tick;
    req_cmd[p]  = c2;
    req_data[p] = b;
    tick;
    req_cmd[p]  = '0;
    req_data[p] = '0;
  endtask

  task automatic issue_mask(input logic [3:0] m,
                            input logic [3:0] c,
                            input logic [31:0] a,
                            input logic [31:0] b);
    tick;
    for (int p = 0; p < 4; p++) if (m[p]) begin
      req_cmd[p]  = c;
      req_data[p] = a + 32'(p);
    end
    tick;
    for (int p = 0; p < 4; p++) if (m[p]) begin
      req_cmd[p]  = '0;
      req_data[p] = b;
    end
    tick;
    for (int p = 0; p < 4; p++) req_data[p] = '0;
  endtask

  function automatic int pending();
    return sbq[0].size() + sbq[1].size()
         + sbq[2].size() + sbq[3].size();
  endfunction

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (pending() != 0 && n < 60) begin
      @(posedge c_clk);
      n++;
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL %s got %0d outstanding want 0",
               nm, pending());
      for (int p = 0; p < 4; p++) sbq[p].delete();
    end
  endtask

  task automatic wait_disp(input int n,
                           input string nm);
    int k;
    k = 0;
    while (disp_q.size() < n && k < 60) begin
      @(posedge c_clk);
      k++;
    end
    chk(nm, disp_q.size(), n);
  endtask

  task automatic do_reset;
    @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);
    reset = 1'b0;
  endtask

  task automatic inject(input logic [2:0] t,
                        input logic [1:0] r,
                        input logic [31:0] d);
    inj_tag  = t;
    inj_resp = r;
    inj_data = d;
    inj_pend = 1'b1;
    repeat (3) @(negedge c_clk);
  endtask

  initial begin : main
    logic [3:0]  r_cmd;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [2:0]  r_tag;
    int          a;

    for (int p = 0; p < 4; p++) begin
      req_cmd[p]  = '0;
      req_data[p] = '0;
      held_tag[p] = '0;
    end

    vt[0] = '{1, 4'd2, 32'd5, 32'd3,
              2'd1, 32'd2};
    vt[1] = '{2, 4'd2, 32'd3, 32'd5,
              2'd2, 32'hFFFF_FFFE};
    vt[2] = '{3, 4'd5, 32'd1, 32'd31,
              2'd1, 32'h8000_0000};
    vt[3] = '{0, 4'd6, 32'h8000_0000, 32'd4,
              2'd1, 32'h0800_0000};
    vt[4] = '{1, 4'd1, 32'hFFFF_FFFF, 32'd1,
              2'd2, 32'd0};
    vt[5] = '{2, 4'd3, 32'd9, 32'd9,
              2'd2, 32'd0};
    vt[6] = '{3, 4'd7, 32'd1, 32'd1,
              2'd2, 32'd0};
    vt[7] = '{0, 4'd15, 32'd1, 32'd1,
              2'd2, 32'd0};
    vt[8] = '{1, 4'd1, 32'h1234_5678,
              32'h1111_1111, 2'd1, 32'h2345_6789};
    vt[9] = '{0, 4'd1, 32'd0, 32'd0,
              2'd1, 32'd0};

    // Reset state, before any clock edge.
    #1;
    chk("rst_valid", alu_valid, 0);
    chk("rst_err", sched_err, 0);
    chk("rst_tag", alu_tag, 0);
    chk("rst_cmd", alu_cmd, 0);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_resp%0d", p + 1),
          out_resp[p], 0);
      chk($sformatf("rst_data%0d", p + 1),
          out_data[p], 0);
    end
    repeat (2) @(negedge c_clk);
    reset = 1'b0;

    // 1: port1 add, latency check.
    tick;
    req_cmd[0]  = 4'd1;
    req_data[0] = 32'h1;
    expect_rsp(0, 2'd1, 32'h0200_0000);
    @(negedge c_clk);
    chk("t1_valid_c0", alu_valid, 0);
    tick;
    req_cmd[0]  = 4'd0;
    req_data[0] = 32'h01FF_FFFF;
    @(negedge c_clk);
    chk("t1_valid_c1", alu_valid, 0);
    tick;
    req_data[0] = '0;
    @(negedge c_clk);
    chk("t1_valid_c2", alu_valid, 1);
    chk("t1_cmd", alu_cmd, 1);
    chk("t1_op1", alu_op1, 32'h1);
    chk("t1_op2", alu_op2, 32'h01FF_FFFF);
    chk("t1_tagport", alu_tag[1:0], 0);
    @(negedge c_clk);
    chk("t1_resp_c3", out_resp[0], 0);
    @(negedge c_clk);
    chk("t1_resp_c4", out_resp[0], 1);
    chk("t1_data_c4", out_data[0], 32'h0200_0000);
    @(negedge c_clk);
    chk("t1_resp_c5", out_resp[0], 0);
    wait_drain("t1_drain");

    // Table of single requests.
    for (int i = 0; i < 10; i++) begin
      expect_rsp(vt[i].port, vt[i].resp,
                 vt[i].data);
      issue(vt[i].port, vt[i].cmd, vt[i].a,
            vt[i].b, 4'd0);
      wait_drain($sformatf("vec%0d_drain", i));
    end

    // 2: all four at once, then ports 2 and 4.
    do_reset;
    disp_q.delete();
    disp_cyc.delete();
    for (int p = 0; p < 4; p++)
      expect_rsp(p, 2'd1, 32'd110 + 32'(p));
    issue_mask(4'b1111, 4'd1, 32'd10, 32'd100);
    wait_drain("t2a_drain");
    chk("t2a_count", disp_q.size(), 4);
    if (disp_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t2a_order%0d", i),
            disp_q[i], i);
        chk($sformatf("t2a_cyc%0d", i),
            disp_cyc[i] - disp_cyc[0], i);
      end
    end
    disp_q.delete();
    expect_rsp(1, 2'd1, 32'd8);
    expect_rsp(3, 2'd1, 32'd10);
    issue_mask(4'b1010, 4'd1, 32'd2, 32'd5);
    wait_drain("t2b_drain");
    chk("t2b_count", disp_q.size(), 2);
    if (disp_q.size() == 2) begin
      chk("t2b_first", disp_q[0], 1);
      chk("t2b_second", disp_q[1], 3);
    end

    // 3: invalid command on port3.
    disp_q.delete();
    expect_rsp(2, 2'd2, 32'd0);
    issue(2, 4'd3, 32'd7, 32'd7, 4'd4);
    @(negedge c_clk);
    chk("t3_resp_c2", out_resp[2], 0);
    @(negedge c_clk);
    chk("t3_resp_c3", out_resp[2], 2);
    chk("t3_data_c3", out_data[2], 0);
    wait_drain("t3_drain");
    repeat (3) @(negedge c_clk);
    chk("t3_no_disp", disp_q.size(), 0);

    // 4: stall with a later port2 request.
    do_reset;
    expect_rsp(0, 2'd1, 32'd5);
    issue(0, 4'd1, 32'd2, 32'd3, 4'd0);
    wait_drain("t4_warm");
    disp_q.delete();
    alu_ready = 1'b0;
    expect_rsp(0, 2'd1, 32'h30);
    issue(0, 4'd1, 32'h10, 32'h20, 4'd0);
    @(negedge c_clk);
    chk("t4_valid0", alu_valid, 1);
    chk("t4_tagport", alu_tag[1:0], 0);
    r_cmd = alu_cmd;
    r_op1 = alu_op1;
    r_op2 = alu_op2;
    r_tag = alu_tag;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge c_clk);
          chk($sformatf("t4_valid%0d", i + 1),
              alu_valid, 1);
          chk($sformatf("t4_stable%0d", i + 1),
              {31'd0, (alu_cmd == r_cmd &&
                       alu_op1 == r_op1 &&
                       alu_op2 == r_op2 &&
                       alu_tag == r_tag)}, 1);
        end
      end
      begin
        expect_rsp(1, 2'd1, 32'd9);
        issue(1, 4'd1, 32'd4, 32'd5, 4'd0);
      end
    join
    tick;
    alu_ready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_count", disp_q.size(), 2);
    if (disp_q.size() == 2) begin
      chk("t4_first", disp_q[0], 0);
      chk("t4_second", disp_q[1], 1);
    end

    // 5: port2 timeout, then late result.
    do_reset;
    disp_q.delete();
    disp_cyc.delete();
    hold = 4'b0010;
    expect_rsp(1, 2'd2, 32'd0);
    issue(1, 4'd1, 32'd7, 32'd8, 4'd0);
    wait_disp(1, "t5_disp");
    a = (disp_cyc.size() > 0) ? disp_cyc[0] : cyc;
    do @(negedge c_clk); while (cyc < a + 15);
    chk("t5_resp_early", out_resp[1], 0);
    @(negedge c_clk);
    chk("t5_resp_to", out_resp[1], 2);
    chk("t5_data_to", out_data[1], 0);
    chk("t5_err_before", sched_err, 0);
    wait_drain("t5_drain");
    inject(held_tag[1], 2'd1, 32'd15);
    chk("t5_err_late", sched_err, 1);
    chk("t5_no_resp", out_resp[1], 0);

    // 6: reset while port4 waits.
    disp_q.delete();
    hold = 4'b1000;
    issue(3, 4'd1, 32'd1, 32'd2, 4'd0);
    wait_disp(1, "t6_disp");
    repeat (2) @(negedge c_clk);
    chk("t6_err_pre", sched_err, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_err_rst", sched_err, 0);
    chk("t6_valid_rst", alu_valid, 0);
    for (int p = 0; p < 4; p++)
      chk($sformatf("t6_resp%0d", p + 1),
          out_resp[p], 0);
    @(negedge c_clk);
    reset = 1'b0;
    inject(held_tag[3], 2'd1, 32'd3);
    chk("t6_err_old", sched_err, 1);
    chk("t6_no_resp", out_resp[3], 0);
    hold = 4'b0000;
    expect_rsp(3, 2'd1, 32'd2);
    issue(3, 4'd2, 32'd5, 32'd3, 4'd0);
    wait_drain("t6_drain");

    repeat (3) @(negedge c_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
